// File: rtl/obstacle_scroller_pkg.sv
// Shared screen geometry, LFSR seed and scroller state encoding for the obstacle path.
package Constants;

  localparam int SCREEN_WIDTH   = 640;
  localparam int SCREEN_HEIGHT  = 480;
  localparam int OBSTACLE_WIDTH = 60;
  localparam int MAX_SPEED      = 6;

  localparam logic [8:0] LFSR_SEED = 9'h1A5;

  typedef enum logic [1:0] {
    IDLE,
    RESPAWN,
    SCROLL
  } obstacle_state_t;

endpackage

// File: rtl/obstacle_scroller_lfsr9.sv
// 9-bit Fibonacci LFSR, x^9+x^5+1, free-running from a fixed nonzero seed.
module lfsr9
  import Constants::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic [8:0] out
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= LFSR_SEED;
    end else begin
      out <= {out[7:0], out[8] ^ out[4]};
    end
  end

endmodule

// File: rtl/obstacle_scroller.sv
// Scrolling pipe obstacle: respawns with a pseudo-random gap, scrolls left, flags bird pass.
// Optional build macro OBSTACLE_SPEEDUP_EN raises the scroll speed every 8 passes.
module obstacle_scroller
  import Constants::*;
#(
  parameter int GAP_SIZE = 120,
  parameter int MIN_PIPE = 40,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       restart,
  output logic [9:0] x,
  output logic [8:0] yBot,
  output logic [8:0] yTop,
  output logic       active,
  output logic       passed
);

  localparam int RANGE = SCREEN_HEIGHT - GAP_SIZE - 2 * MIN_PIPE;
  localparam int OPEN  = SCREEN_HEIGHT - GAP_SIZE;

  localparam logic [9:0] X_PARK = 10'(SCREEN_WIDTH);
  localparam logic [8:0] Y_PARK = 9'(OPEN / 2);

  if (RANGE < 256 || RANGE > 511) begin : g_range_check
    $error("obstacle_scroller: gap RANGE must lie in [256,511]");
  end

  obstacle_state_t state;
  logic [8:0]      lfsr;
  logic [2:0]      spd;
  logic [8:0]      r;
  logic [8:0]      top_next;
  logic [8:0]      bot_next;
  logic [9:0]      x_dec;
  logic            can_step;
  logic            will_pass;
  logic            pass_event;

  lfsr9 u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .out     (lfsr)
  );

  // A single conditional subtract folds the 9-bit LFSR range onto [0, RANGE).
  always_comb begin
    // NOTE: give r its default first so no latch is inferred on the untaken branch.
    r = lfsr;
    if (r >= 9'(RANGE)) r = r - 9'(RANGE);
    top_next = 9'(MIN_PIPE) + r;
    bot_next = 9'(OPEN) - top_next;
  end

  assign x_dec      = x - {7'b0, spd};
  assign can_step   = (x >= {7'b0, spd});
  assign will_pass  = (({1'b0, x} + 11'(OBSTACLE_WIDTH)) >= 11'(BIRD_X)) &&
                      (({1'b0, x_dec} + 11'(OBSTACLE_WIDTH)) < 11'(BIRD_X));
  assign pass_event = !restart && (state == SCROLL) && enable && frame_tick &&
                      can_step && will_pass;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      x      <= X_PARK;
      yTop   <= Y_PARK;
      yBot   <= Y_PARK;
      active <= 1'b0;
      passed <= 1'b0;
    end else begin
      passed <= pass_event;
      if (restart) begin
        state  <= IDLE;
        x      <= X_PARK;
        yTop   <= Y_PARK;
        yBot   <= Y_PARK;
        active <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (enable) begin
              state  <= RESPAWN;
              active <= 1'b1;
            end
          end
          RESPAWN: begin
            x     <= X_PARK;
            yTop  <= top_next;
            yBot  <= bot_next;
            state <= SCROLL;
          end
          SCROLL: begin
            if (enable && frame_tick) begin
              if (can_step) x <= x_dec;
              else          state <= RESPAWN;
            end
          end
          default: begin
            state  <= IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  logic [2:0] pass_cnt;

  // The counter wraps every 8 passes; each wrap bumps the speed up to the cap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pass_cnt <= 3'd0;
      spd      <= 3'(SPEED);
    end else if (restart) begin
      pass_cnt <= 3'd0;
      spd      <= 3'(SPEED);
    end else if (pass_event) begin
      pass_cnt <= pass_cnt + 3'd1;
      if (pass_cnt == 3'd7 && spd < 3'(MAX_SPEED)) spd <= spd + 3'd1;
    end
  end
`else
  assign spd = 3'(SPEED);
`endif

endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: park values, respawn gap, sweep, pass pulse, hold, restart, reset, speed.
module tb_obstacle_scroller;

  logic       clk;
  logic       reset_n;
  logic       frame_tick;
  logic       enable;
  logic       restart;
  logic [9:0] x;
  logic [8:0] yBot;
  logic [8:0] yTop;
  logic       active;
  logic       passed;

  int vectors     = 0;
  int miscompares = 0;
  int pass_seen   = 0;

  obstacle_scroller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_tick (frame_tick),
    .enable     (enable),
    .restart    (restart),
    .x          (x),
    .yBot       (yBot),
    .yTop       (yTop),
    .active     (active),
    .passed     (passed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given frame_tick; outputs sampled 1ns after the edge.
  task automatic step(input logic ft);
    frame_tick = ft;
    @(posedge clk);
    #1;
    if (passed) pass_seen++;
  endtask

  task automatic check_gap(input string tag);
    check({tag, "_sum"}, int'(yTop) + int'(yBot), 360);
    check({tag, "_top_min"}, yTop >= 9'd40, 1);
    check({tag, "_top_max"}, yTop <= 9'd320, 1);
    check({tag, "_bot_min"}, yBot >= 9'd40, 1);
  endtask

  task automatic run_passes(input string tag, input int n);
    int guard;
    guard     = 0;
    pass_seen = 0;
    while (pass_seen < n && guard < 20000) begin
      step(1'b1);
      guard++;
    end
    check(tag, pass_seen, n);
  endtask

  task automatic measure_step(output int d);
    logic [9:0] old_x;
    d = -1;
    for (int i = 0; i < 700; i++) begin
      old_x = x;
      step(1'b1);
      if (x < old_x) begin
        d = int'(old_x) - int'(x);
        break;
      end
    end
  endtask

  initial begin
    int         pulses;
    int         pulse_x;
    int         viol;
    int         changes;
    int         d;
    logic [8:0] prev_top;

    reset_n    = 1'b0;
    frame_tick = 1'b0;
    enable     = 1'b0;
    restart    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Reset state and idle without enable.
    check("rst_x", x, 640);
    check("rst_ytop", yTop, 180);
    check("rst_ybot", yBot, 180);
    check("rst_active", active, 0);
    check("rst_passed", passed, 0);
    for (int i = 0; i < 6; i++) step(1'b1);
    check("idle_x", x, 640);
    check("idle_ytop", yTop, 180);
    check("idle_active", active, 0);
    check("idle_passed", pass_seen, 0);

    // Enable: RESPAWN after one edge, SCROLL with a fresh gap after two.
    enable = 1'b1;
    step(1'b1);
    check("respawn_active", active, 1);
    check("respawn_x", x, 640);
    step(1'b1);
    check("scroll_entry_x", x, 640);
    check_gap("first_gap");

    // Full sweep at speed 2: single pass pulse at x 40 -> 38, x reaches 0 after 320 ticks.
    pulses  = 0;
    pulse_x = -1;
    for (int k = 1; k <= 320; k++) begin
      step(1'b1);
      if (passed) begin
        pulses++;
        pulse_x = int'(x);
      end
    end
    check("sweep_x_end", x, 0);
    check("sweep_pulses", pulses, 1);
    check("sweep_pulse_x", pulse_x, 38);
    step(1'b1);
    check("wrap_x_hold", x, 0);
    check("wrap_active", active, 1);
    check("wrap_passed", passed, 0);
    step(1'b0);
    check("wrap_new_x", x, 640);
    check_gap("wrap_gap");

    // Scroll to 300, hold with enable low, then restart wins over enable and tick.
    for (int k = 0; k < 170; k++) step(1'b1);
    check("at_300", x, 300);
    enable = 1'b0;
    for (int k = 0; k < 5; k++) step(1'b1);
    check("hold_x", x, 300);
    check("hold_active", active, 1);
    enable  = 1'b1;
    restart = 1'b1;
    step(1'b1);
    restart = 1'b0;
    enable  = 1'b0;
    check("restart_x", x, 640);
    check("restart_active", active, 0);
    check("restart_ytop", yTop, 180);
    check("restart_ybot", yBot, 180);

    // Many respawns via restart: gap invariants must never break, gap must keep moving.
    viol     = 0;
    changes  = 0;
    prev_top = 9'd0;
    for (int n = 0; n < 1000; n++) begin
      enable = 1'b1;
      step(1'b0);
      step(1'b0);
      if (x != 10'd640 || (int'(yTop) + int'(yBot)) != 360 ||
          yTop < 9'd40 || yTop > 9'd320 || yBot < 9'd40) viol++;
      if (n > 0 && yTop != prev_top) changes++;
      prev_top = yTop;
      enable  = 1'b0;
      restart = 1'b1;
      step(1'b0);
      restart = 1'b0;
    end
    check("respawn_violations", viol, 0);
    check("respawn_gap_varies", changes >= 500, 1);

    // Reset asserted at x=42, one tick before the pass point: no pulse may follow.
    enable = 1'b1;
    step(1'b1);
    step(1'b1);
    for (int k = 0; k < 299; k++) step(1'b1);
    check("pre_reset_x", x, 42);
    enable     = 1'b0;
    frame_tick = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_x", x, 640);
    check("async_rst_active", active, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    pass_seen = 0;
    for (int k = 0; k < 4; k++) step(1'b1);
    check("post_rst_passed", pass_seen, 0);
    check("post_rst_active", active, 0);

    // Speed after repeated passes.
    enable = 1'b1;
`ifdef OBSTACLE_SPEEDUP_EN
    run_passes("passes_8", 8);
    measure_step(d);
    check("spd_after_8", d, 3);
    run_passes("passes_32", 24);
    measure_step(d);
    check("spd_after_32", d, 6);
    run_passes("passes_40", 8);
    measure_step(d);
    check("spd_saturated", d, 6);
`else
    run_passes("passes_9", 9);
    measure_step(d);
    check("spd_after_9", d, 2);
    run_passes("passes_12", 3);
    measure_step(d);
    check("spd_after_12", d, 2);
`endif
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/obstacle_scroller.md
OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 SHALL have parameter GAP_SIZE, default 120, vertical gap height in pixels.
REQ-002 SHALL have parameter MIN_PIPE, default 40, minimum pipe height in pixels.
REQ-003 SHALL have parameter SPEED, default 2, pixels moved per frame_tick.
REQ-004 SHALL have parameter BIRD_X, default 100, bird left column used for pass detection.
REQ-005 SHALL have ports: clk in 1, system clock; reset_n in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: frame_tick in 1, one-cycle pulse per video frame; enable in 1, game running; restart in 1, synchronous return to IDLE.
REQ-007 SHALL have outputs: x out 10, obstacle left edge; yBot out 9, bottom pipe height measured from screen bottom; yTop out 9, top pipe height measured from row 0.
REQ-008 SHALL have outputs: active out 1, state is not IDLE; passed out 1, one-cycle pulse when the obstacle clears the bird.

Function
REQ-009 SHALL use states IDLE, RESPAWN and SCROLL, with all outputs registered.
REQ-010 IDLE: outputs SHALL hold their park values; when enable=1 the block SHALL move to RESPAWN.
REQ-011 RESPAWN (exactly 1 cycle) SHALL load x=SCREEN_WIDTH and a new gap, then move to SCROLL; frame_tick SHALL be ignored in RESPAWN.
REQ-012 SCROLL, on frame_tick=1 and enable=1: if x>=spd then x SHALL become x-spd on the next edge; otherwise the block SHALL move to RESPAWN with x unchanged.
REQ-013 SCROLL, on enable=0: x, yTop, yBot and the state SHALL hold.
REQ-014 The gap SHALL come from a 9-bit LFSR (polynomial x^9+x^5+1, seed 9'h1A5) that advances every clock in every state and never reaches zero.
REQ-015 Gap arithmetic: r=lfsr; if r>=RANGE then r=r-RANGE, where RANGE=SCREEN_HEIGHT-GAP_SIZE-2*MIN_PIPE (default 280); yTop SHALL be MIN_PIPE+r and yBot SHALL be SCREEN_HEIGHT-GAP_SIZE-yTop.
REQ-016 yTop+yBot SHALL always equal SCREEN_HEIGHT-GAP_SIZE, and both SHALL be >=MIN_PIPE.
REQ-017 An elaboration-time check SHALL fail if RANGE is outside [256,511].
REQ-018 passed SHALL pulse high for 1 cycle, in the cycle after the x update, when the old x+OBSTACLE_WIDTH>=BIRD_X and the new x+OBSTACLE_WIDTH<BIRD_X.
REQ-019 passed SHALL occur at most once per sweep and never in RESPAWN or IDLE.
REQ-020 x+OBSTACLE_WIDTH SHALL be computed 11 bits wide, with no wrap.
REQ-021 restart=1 SHALL win over enable and frame_tick: on the next edge the block SHALL enter IDLE with park values and spd=SPEED.
REQ-022 restart SHALL NOT reseed the LFSR.
REQ-023 active SHALL be 0 in IDLE and 1 otherwise.

Reset
REQ-024 reset_n=0 SHALL immediately set: state IDLE, x=640, yTop=180, yBot=180, passed=0, active=0, lfsr=9'h1A5, spd=SPEED.
REQ-025 An assertion of reset_n mid-sweep SHALL abandon the sweep with no passed pulse.
REQ-026 Park values SHALL be x=SCREEN_WIDTH and yTop=yBot=(SCREEN_HEIGHT-GAP_SIZE)/2.

Configuration
REQ-027 With OBSTACLE_SPEEDUP_EN defined, spd SHALL increment by 1 after every 8th passed pulse, saturating at MAX_SPEED=6; the pass counter is 3 bits and wraps.
REQ-028 Without OBSTACLE_SPEEDUP_EN, spd SHALL be the constant SPEED and no pass counter SHALL exist.

Structure
REQ-029 SCREEN_WIDTH (640), SCREEN_HEIGHT (480), OBSTACLE_WIDTH (60) and MAX_SPEED (6) SHALL come from package Constants.
REQ-030 The state enum obstacle_state_t SHALL be defined in Constants.
REQ-031 The LFSR SHALL be a sub-module lfsr9 with ports clk, reset_n, out[8:0].
REQ-032 Outputs x, yBot and yTop SHALL feed the video-format stage unchanged.

Verification
REQ-033 Reset then release, no enable -> x=640, yTop=180, yBot=180, active=0, passed=0 indefinitely.
REQ-034 enable=1 -> RESPAWN after 1 cycle, SCROLL after 2; x=640, 40<=yTop<=320, yTop+yBot=360; repeat over 1000 respawns with no violation.
REQ-035 SPEED=2, enable held, 320 frame_ticks -> x=0; tick 321 -> RESPAWN, then x=640 with a new gap.
REQ-036 Sweep with BIRD_X=100 -> exactly one passed pulse, on the tick where x goes 40->38; no other pulse in that sweep.
REQ-037 At x=300: enable=0 for 5 ticks -> x stays 300; then restart=1 -> next cycle IDLE, x=640, active=0, yTop=yBot=180.
REQ-038 With OBSTACLE_SPEEDUP_EN: after 8 passes spd=3 (x steps of 3); after 32 passes spd=6 and it stays 6. Without the macro, spd stays 2 throughout.
